// File: rtl/g_logic_pkg.sv
// Shared gate-mode constants and helpers for the N-input logic filter.
// Reduction is written over a fixed-width vector so one function serves every WIDTH.
package g_logic_pkg;

    localparam int unsigned MODE_AND  = 0;
    localparam int unsigned MODE_OR   = 1;
    localparam int unsigned MODE_NAND = 2;
    localparam int unsigned MODE_NOR  = 3;
    localparam int unsigned MODE_XOR  = 4;
    localparam int unsigned MODE_XNOR = 5;

    localparam int unsigned MAX_WIDTH = 16;

    // Only the low 'width' bits of vec take part in the reduction.
    function automatic logic g_reduce(input int unsigned mode,
                                      input logic [MAX_WIDTH-1:0] vec,
                                      input int unsigned width);
        logic r_and;
        logic r_or;
        logic r_xor;
        logic r;
        r_and = 1'b1;
        r_or  = 1'b0;
        r_xor = 1'b0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                r_and = r_and & vec[i];
                r_or  = r_or | vec[i];
                r_xor = r_xor ^ vec[i];
            end
        end
        case (mode)
            MODE_AND:  r = r_and;
            MODE_OR:   r = r_or;
            MODE_NAND: r = ~r_and;
            MODE_NOR:  r = ~r_or;
            MODE_XOR:  r = r_xor;
            MODE_XNOR: r = ~r_xor;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic g_idle(input int unsigned mode);
        return g_reduce(mode, '0, 1);
    endfunction

endpackage

// File: rtl/g_deglitch.sv
// One-channel deglitcher: Y follows YRAW only after YRAW has disagreed with Y
// for FILT+1 consecutive enabled edges; CHG pulses on the edge Y changes.
module g_deglitch #(
    parameter int unsigned FILT = 2,
    parameter logic        IDLE = 1'b1
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic EN,
    input  logic YRAW,
    output logic Y,
    output logic CHG
);

    localparam logic [3:0] FILT_CNT = FILT[3:0];

    logic [3:0] cnt_q, cnt_d;
    logic       y_q, y_d;
    logic       chg_q, chg_d;

    always_comb begin
        cnt_d = cnt_q;
        y_d   = y_q;
        chg_d = 1'b0;
        if (EN) begin
            if (YRAW == y_q) begin
                cnt_d = '0;
            end else if (cnt_q == FILT_CNT) begin
                y_d   = YRAW;
                cnt_d = '0;
                chg_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q <= '0;
            y_q   <= IDLE;
            chg_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            y_q   <= y_d;
            chg_q <= chg_d;
        end
    end

    assign Y   = y_q;
    assign CHG = chg_q;

endmodule

// File: rtl/g_nlogic_filt.sv
// Multi-channel N-input gate with a registered raw result and a per-channel
// deglitch filter on top of it.
module g_nlogic_filt
    import g_logic_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned MODE     = 3,
    parameter int unsigned FILT     = 2
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      EN,
    input  logic [CHANNELS*WIDTH-1:0] D,
    output logic [CHANNELS-1:0]       YRAW,
    output logic [CHANNELS-1:0]       Y,
    output logic [CHANNELS-1:0]       CHG
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "g_nlogic_filt: WIDTH must be in 2..16");
    end
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $fatal(1, "g_nlogic_filt: CHANNELS must be in 1..8");
    end
    if (MODE > 5) begin : g_bad_mode
        $fatal(1, "g_nlogic_filt: MODE must be in 0..5");
    end
    if (FILT > 15) begin : g_bad_filt
        $fatal(1, "g_nlogic_filt: FILT must be in 0..15");
    end

    localparam logic IDLE = g_idle(MODE);

    logic [CHANNELS-1:0] gate;
    logic [CHANNELS-1:0] yraw_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign gate[c] = g_reduce(MODE, MAX_WIDTH'(D[c*WIDTH +: WIDTH]), WIDTH);

        g_deglitch #(
            .FILT (FILT),
            .IDLE (IDLE)
        ) u_deglitch (
            .CLK  (CLK),
            .RSTN (RSTN),
            .EN   (EN),
            .YRAW (yraw_q[c]),
            .Y    (Y[c]),
            .CHG  (CHG[c])
        );
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            yraw_q <= {CHANNELS{IDLE}};
        end else if (EN) begin
            yraw_q <= gate;
        end
    end

    assign YRAW = yraw_q;

endmodule

// File: tb/tb_g_nlogic_filt.sv
// Scoreboard bench: three instances (default NOR, 4-channel XOR unfiltered,
// FILT=15) driven one at a time against a cycle model of the filter.
module tb_g_nlogic_filt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rstn = 1'b0, a_en = 1'b0;
    logic [2:0] a_d = '0;
    logic [0:0] a_yraw, a_y, a_chg;

    logic        b_rstn = 1'b0, b_en = 1'b0;
    logic [31:0] b_d = '0;
    logic [3:0]  b_yraw, b_y, b_chg;

    logic       c_rstn = 1'b0, c_en = 1'b0;
    logic [2:0] c_d = '0;
    logic [0:0] c_yraw, c_y, c_chg;

    g_nlogic_filt u_dut_a (
        .CLK(clk), .RSTN(a_rstn), .EN(a_en), .D(a_d), .YRAW(a_yraw), .Y(a_y), .CHG(a_chg)
    );

    g_nlogic_filt #(.WIDTH(8), .CHANNELS(4), .MODE(4), .FILT(0)) u_dut_b (
        .CLK(clk), .RSTN(b_rstn), .EN(b_en), .D(b_d), .YRAW(b_yraw), .Y(b_y), .CHG(b_chg)
    );

    g_nlogic_filt #(.FILT(15)) u_dut_c (
        .CLK(clk), .RSTN(c_rstn), .EN(c_en), .D(c_d), .YRAW(c_yraw), .Y(c_y), .CHG(c_chg)
    );

    int errors = 0;
    int checks = 0;

    int          sel, m_ch, m_w, m_mode, m_filt;
    logic [3:0]  m_yraw, m_y;
    int          m_run[4];
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Gate value from the count of ones among the first w bits.
    function automatic logic model_gate(input logic [7:0] v, input int w, input int mode);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += int'(v[i]);
        case (mode)
            0:       return ones == w;
            1:       return ones != 0;
            2:       return ones != w;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            default: return (ones % 2) == 0;
        endcase
    endfunction

    function automatic logic [11:0] dut_out();
        case (sel)
            0:       return {3'b000, a_yraw, 3'b000, a_y, 3'b000, a_chg};
            1:       return {b_yraw, b_y, b_chg};
            default: return {3'b000, c_yraw, 3'b000, c_y, 3'b000, c_chg};
        endcase
    endfunction

    task automatic set_dut(input int s, input int ch, input int w, input int mode, input int filt);
        sel = s; m_ch = ch; m_w = w; m_mode = mode; m_filt = filt;
    endtask

    task automatic set_rst(input logic v);
        case (sel)
            0:       a_rstn = v;
            1:       b_rstn = v;
            default: c_rstn = v;
        endcase
    endtask

    task automatic drive(input logic [31:0] d, input logic en);
        case (sel)
            0:       begin a_d = d[2:0]; a_en = en; end
            1:       begin b_d = d;      b_en = en; end
            default: begin c_d = d[2:0]; c_en = en; end
        endcase
    endtask

    // Asserts reset between edges and checks the idle outputs before any clock.
    task automatic do_reset(input string tag);
        logic idle;
        @(negedge clk);
        set_rst(1'b0);
        #1;
        idle = (m_mode == 2 || m_mode == 3 || m_mode == 5);
        m_yraw = '0;
        m_y    = '0;
        for (int c = 0; c < m_ch; c++) begin
            m_yraw[c] = idle;
            m_y[c]    = idle;
            m_run[c]  = 0;
        end
        exp_q.delete();
        check(tag, 32'(dut_out()), 32'({m_yraw, m_y, 4'b0000}));
        @(negedge clk);
        case (sel)
            0:       a_en = 1'b0;
            1:       b_en = 1'b0;
            default: c_en = 1'b0;
        endcase
        @(negedge clk);
        set_rst(1'b1);
    endtask

    task automatic cycle(input logic [31:0] d, input logic en, input string tag);
        logic [3:0]  chg;
        logic [11:0] exp;
        @(negedge clk);
        drive(d, en);
        chg = '0;
        for (int c = 0; c < m_ch; c++) begin
            logic g;
            g = model_gate(8'(d >> (c * m_w)), m_w, m_mode);
            if (en) begin
                if (m_yraw[c] != m_y[c]) begin
                    m_run[c]++;
                    if (m_run[c] > m_filt) begin
                        m_y[c]   = m_yraw[c];
                        chg[c]   = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_yraw[c] = g;
            end
        end
        exp_q.push_back({m_yraw, m_y, chg});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check(tag, 32'(dut_out()), 32'(exp));
    endtask

    initial begin
        // Reset and idle, default NOR / FILT=2
        set_dut(0, 1, 3, 3, 2);
        do_reset("rst_a");
        check("rst_a_yraw", 32'(a_yraw), 1);
        check("rst_a_y", 32'(a_y), 1);
        check("rst_a_chg", 32'(a_chg), 0);
        repeat (6) cycle(32'h0, 1'b1, "idle_a");

        // Clean step: YRAW at edge n, Y and CHG at edge n+3
        cycle(32'h2, 1'b1, "step_n");
        check("step_yraw_n", 32'(a_yraw), 0);
        cycle(32'h2, 1'b1, "step_n1");
        cycle(32'h2, 1'b1, "step_n2");
        check("step_y_n2", 32'(a_y), 1);
        cycle(32'h2, 1'b1, "step_n3");
        check("step_y_n3", 32'(a_y), 0);
        check("step_chg_n3", 32'(a_chg), 1);
        cycle(32'h2, 1'b1, "step_n4");
        check("step_chg_n4", 32'(a_chg), 0);
        repeat (5) cycle(32'h0, 1'b1, "step_back");

        // Glitch reject (2 cycles) and accept (3 cycles)
        repeat (2) cycle(32'h2, 1'b1, "glitch2");
        repeat (5) cycle(32'h0, 1'b1, "glitch2_after");
        check("glitch2_y", 32'(a_y), 1);
        repeat (3) cycle(32'h2, 1'b1, "glitch3");
        cycle(32'h0, 1'b1, "glitch3_edge");
        check("glitch3_y", 32'(a_y), 0);
        check("glitch3_chg", 32'(a_chg), 1);
        repeat (5) cycle(32'h0, 1'b1, "glitch3_after");

        // Enable hold after one counted cycle
        cycle(32'h2, 1'b1, "hold_load");
        cycle(32'h2, 1'b1, "hold_cnt1");
        repeat (5) cycle(32'h2, 1'b0, "hold_off");
        check("hold_y_frozen", 32'(a_y), 1);
        cycle(32'h2, 1'b1, "hold_cnt2");
        check("hold_y_cnt2", 32'(a_y), 1);
        cycle(32'h2, 1'b1, "hold_fire");
        check("hold_y_fire", 32'(a_y), 0);
        check("hold_chg_fire", 32'(a_chg), 1);
        repeat (5) cycle(32'h0, 1'b1, "hold_back");

        // Four XOR channels, no filtering
        set_dut(1, 4, 8, 4, 0);
        do_reset("rst_b");
        cycle(32'h80FF0301, 1'b1, "par_load");
        check("par_yraw", 32'(b_yraw), 32'h9);
        cycle(32'h80FF0301, 1'b1, "par_y");
        check("par_y", 32'(b_y), 32'h9);
        check("par_chg", 32'(b_chg), 32'h9);
        cycle(32'h00070100, 1'b1, "all_load");
        cycle(32'h00070100, 1'b1, "all_y");
        check("all_chg", 32'(b_chg), 32'hF);
        cycle(32'h00070101, 1'b1, "one_load");
        cycle(32'h00070101, 1'b1, "one_y");
        check("one_chg", 32'(b_chg), 32'h1);
        repeat (2) cycle(32'h00070101, 1'b1, "one_hold");

        // FILT=15 with reset landing mid-count
        set_dut(2, 1, 3, 3, 15);
        do_reset("rst_c");
        repeat (3) cycle(32'h0, 1'b1, "c_idle");
        repeat (7) cycle(32'h2, 1'b1, "c_partial");
        do_reset("rst_c_mid");
        repeat (16) cycle(32'h2, 1'b1, "c_count");
        check("c_y_before", 32'(c_y), 1);
        cycle(32'h2, 1'b1, "c_fire");
        check("c_y_fire", 32'(c_y), 0);
        check("c_chg_fire", 32'(c_chg), 1);
        cycle(32'h2, 1'b1, "c_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
